spi_dispatch: RTL and testbench

- Parametrised successor to the per-device fixed-divider SPI masters driving ADF4002, LMX2594, TRX and AUX chains.
- One shared shift engine serves N_CH SPI lanes.
- Commands are queued; each carries its own lane, bit count, clock divider and read flag.
- Readback via MISO (e.g. mout pins) is returned on a response strobe.
- Sits between process and the SPI pins. Replaces separate spi_master instances and the spi_start/spi_ready bus.

---
 rtl/spi_dispatch_pkg.sv | 38 +++
 rtl/spi_cmd_fifo.sv | 63 ++++++
 rtl/spi_dispatch.sv | 208 ++++++++++++++++++++
 tb/tb_spi_dispatch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dispatch_pkg.sv
// Shared types and command-word layout for the queued multi-lane SPI dispatcher.
// Command word layout, MSB to LSB: {ch, nbits, div, read, data}.
package spi_dispatch_pkg;

   localparam int MAX_BITS_DEF = 54;
   localparam int NBITS_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SETUP = 3'd2,
      ST_HIGH  = 3'd3,
      ST_LOW   = 3'd4,
      ST_HOLD  = 3'd5,
      ST_GAP   = 3'd6
   } state_e;

   function automatic int off_read(input int max_bits);
      return max_bits;
   endfunction

   function automatic int off_div(input int max_bits);
      return max_bits + 1;
   endfunction

   function automatic int off_nbits(input int max_bits, input int div_w);
      return max_bits + 1 + div_w;
   endfunction

   function automatic int off_ch(input int max_bits, input int div_w);
      return off_nbits(max_bits, div_w) + NBITS_W;
   endfunction

   function automatic int cmd_width(input int ch_w, input int max_bits, input int div_w);
      return ch_w + NBITS_W + div_w + 1 + max_bits;
   endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; full and empty are registered so cmd_ready has no
// combinational dependence on the pop from the engine.
module spi_cmd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CNT_W'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   // Storage needs no reset: contents are only observed behind the empty flag.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end

   assign rdata = mem_q[rd_q];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/spi_dispatch.sv
// Queued SPI dispatcher: one mode-0 shift engine serving N_CH lanes, each
// command carrying its own lane, bit count, SCLK divider and read flag.
module spi_dispatch
   import spi_dispatch_pkg::*;
#(
   parameter int N_CH      = 3,
   parameter int MAX_BITS  = MAX_BITS_DEF,
   parameter int CMD_DEPTH = 4,
   parameter int DIV_W     = 8,
   parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [CH_W-1:0]     cmd_ch,
   input  logic [NBITS_W-1:0]  cmd_nbits,
   input  logic [DIV_W-1:0]    cmd_div,
   input  logic                cmd_read,
   input  logic [MAX_BITS-1:0] cmd_data,
   output logic                rsp_valid,
   output logic [CH_W-1:0]     rsp_ch,
   output logic [MAX_BITS-1:0] rsp_data,
   output logic                busy,
   output logic                err_bad_cmd,
   output logic [N_CH-1:0]     spi_sclk,
   output logic [N_CH-1:0]     spi_mosi,
   output logic [N_CH-1:0]     spi_le,
   input  logic [N_CH-1:0]     spi_miso,
   output logic [2:0]          dbg_state
);

   localparam int FW       = cmd_width(CH_W, MAX_BITS, DIV_W);
   localparam int OFF_READ = off_read(MAX_BITS);
   localparam int OFF_DIV  = off_div(MAX_BITS);
   localparam int OFF_NB   = off_nbits(MAX_BITS, DIV_W);
   localparam int OFF_CH   = off_ch(MAX_BITS, DIV_W);
   localparam int BIT_W    = $clog2(MAX_BITS);
   localparam logic [NBITS_W-1:0] MAX_NB = NBITS_W'(MAX_BITS);
   localparam logic [CH_W:0]      NCH_L  = (CH_W + 1)'(N_CH);

   logic          accept, bad, pop, fifo_full, fifo_empty;
   logic [FW-1:0] head;

   assign accept = cmd_valid && cmd_ready;
   assign bad    = (cmd_nbits == '0) || (cmd_nbits > MAX_NB) || ({1'b0, cmd_ch} >= NCH_L);

   spi_cmd_fifo #(.W(FW), .DEPTH(CMD_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept && !bad),
      .wdata ({cmd_ch, cmd_nbits, cmd_div, cmd_read, cmd_data}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   state_e              state_q, state_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d, first_bit;
   logic [CH_W-1:0]     ch_q, ch_d, rsp_ch_q, rsp_ch_d;
   logic [NBITS_W-1:0]  nbits_q, nbits_d;
   logic                read_q, read_d, rsp_valid_q, rsp_valid_d, err_q;
   logic [MAX_BITS-1:0] data_q, data_d, rx_q, rx_d, rsp_data_q, rsp_data_d, rx_shift;
   logic [N_CH-1:0]     sclk_q, sclk_d, mosi_q, mosi_d, le_q, le_d;
   logic                phase_done;

   // A divider of 0 runs at the same rate as 1.
   assign phase_done = (div_q == '0) ? 1'b1 : (cnt_q == div_q - 1'b1);
   assign first_bit  = BIT_W'(nbits_q - 1'b1);
   assign rx_shift   = {rx_q[MAX_BITS-2:0], spi_miso[ch_q]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_d       = bit_q;
      ch_d        = ch_q;
      nbits_d     = nbits_q;
      div_d       = div_q;
      read_d      = read_q;
      data_d      = data_q;
      rx_d        = rx_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      le_d        = le_q;
      rsp_valid_d = 1'b0;
      rsp_ch_d    = rsp_ch_q;
      rsp_data_d  = rsp_data_q;
      pop         = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               ch_d    = head[OFF_CH +: CH_W];
               nbits_d = head[OFF_NB +: NBITS_W];
               div_d   = head[OFF_DIV +: DIV_W];
               read_d  = head[OFF_READ];
               data_d  = head[MAX_BITS-1:0];
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d          = '0;
            le_d           = '1;
            le_d[ch_q]     = 1'b0;
            mosi_d         = '0;
            mosi_d[ch_q]   = data_q[first_bit];
            bit_d          = first_bit;
            rx_d           = '0;
            state_d        = ST_SETUP;
         end
         // MISO is captured on the same edge that raises SCLK.
         ST_SETUP, ST_LOW: begin
            if (phase_done) begin
               cnt_d        = '0;
               sclk_d[ch_q] = 1'b1;
               rx_d         = rx_shift;
               state_d      = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (phase_done) begin
               cnt_d  = '0;
               sclk_d = '0;
               if (bit_q != '0) begin
                  bit_d        = bit_q - 1'b1;
                  mosi_d[ch_q] = data_q[bit_q - 1'b1];
                  state_d      = ST_LOW;
               end else begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (phase_done) begin
               cnt_d  = '0;
               le_d   = '1;
               mosi_d = '0;
               if (read_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_ch_d    = ch_q;
                  rsp_data_d  = rx_q;
               end
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (phase_done) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         ch_q        <= '0;
         nbits_q     <= '0;
         div_q       <= '0;
         read_q      <= 1'b0;
         data_q      <= '0;
         rx_q        <= '0;
         sclk_q      <= '0;
         mosi_q      <= '0;
         le_q        <= '1;
         rsp_valid_q <= 1'b0;
         rsp_ch_q    <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         ch_q        <= ch_d;
         nbits_q     <= nbits_d;
         div_q       <= div_d;
         read_q      <= read_d;
         data_q      <= data_d;
         rx_q        <= rx_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         le_q        <= le_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ch_q    <= rsp_ch_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= accept && bad;
      end
   end

   assign cmd_ready   = !fifo_full;
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_ch      = rsp_ch_q;
   assign rsp_data    = rsp_data_q;
   assign err_bad_cmd = err_q;
   assign spi_sclk    = sclk_q;
   assign spi_mosi    = mosi_q;
   assign spi_le      = le_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_dispatch.sv
// Directed bench for spi_dispatch: a negedge monitor per lane acts as the SPI
// slave (drives MISO on falling SCLK, captures MOSI on rising SCLK).
`timescale 1ns/1ps
module tb_spi_dispatch;
   import spi_dispatch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_ch = '0;
   logic [7:0]  cmd_nbits = '0;
   logic [7:0]  cmd_div = '0;
   logic        cmd_read = 1'b0;
   logic [53:0] cmd_data = '0;
   logic        rsp_valid;
   logic [1:0]  rsp_ch;
   logic [53:0] rsp_data;
   logic        busy, err_bad_cmd;
   logic [2:0]  spi_sclk, spi_mosi, spi_le;
   logic [2:0]  spi_miso = '0;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   spi_dispatch dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_nbits(cmd_nbits), .cmd_div(cmd_div), .cmd_read(cmd_read),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data),
      .busy(busy), .err_bad_cmd(err_bad_cmd), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_le(spi_le), .spi_miso(spi_miso), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- monitor / slave model ----------------
   int          active_cnt, err_cnt, rsp_cnt, rsp_align;
   logic        busy_seen;
   logic [53:0] rsp_data_last;
   logic [1:0]  rsp_ch_last;
   int          rise_cnt [3];
   int          le_low_cnt [3];
   int          frame_cnt [3];
   logic [63:0] cap [3];
   logic [53:0] miso_word [3];
   int          miso_nb [3];
   int          miso_bit [3];
   logic [2:0]  prev_le = 3'b111;
   logic [2:0]  prev_sclk = 3'b000;
   logic [53:0] got_q [$];
   int          got_ch_q [$];
   int          fall_q [$];
   logic [53:0] exp_q [$];
   int          exp_ch_q [$];

   task automatic clear_mon();
      active_cnt = 0; err_cnt = 0; rsp_cnt = 0; rsp_align = 0; busy_seen = 1'b0;
      rsp_data_last = '0; rsp_ch_last = '0;
      for (int l = 0; l < 3; l++) begin
         rise_cnt[l] = 0; le_low_cnt[l] = 0; frame_cnt[l] = 0; cap[l] = '0;
         miso_word[l] = '0; miso_nb[l] = 0; miso_bit[l] = 0;
      end
      got_q.delete(); got_ch_q.delete(); fall_q.delete();
      exp_q.delete(); exp_ch_q.delete();
   endtask

   always @(negedge clk) begin
      if (dbg_state != ST_IDLE) active_cnt++;
      if (busy) busy_seen = 1'b1;
      if (err_bad_cmd) err_cnt++;
      if (rsp_valid) begin
         rsp_cnt++;
         rsp_data_last = rsp_data;
         rsp_ch_last   = rsp_ch;
         if (spi_le[rsp_ch] && !prev_le[rsp_ch]) rsp_align++;
      end
      for (int l = 0; l < 3; l++) begin
         if (!spi_le[l]) le_low_cnt[l]++;
         if (prev_le[l] && !spi_le[l]) begin
            frame_cnt[l]++;
            fall_q.push_back(cyc);
            cap[l] = '0;
            miso_bit[l] = miso_nb[l] - 1;
            spi_miso[l] = (miso_nb[l] > 0) ? miso_word[l][miso_bit[l]] : 1'b0;
         end
         if (!prev_sclk[l] && spi_sclk[l]) begin
            rise_cnt[l]++;
            cap[l] = {cap[l][62:0], spi_mosi[l]};
         end
         if (prev_sclk[l] && !spi_sclk[l] && !spi_le[l] && miso_bit[l] > 0) begin
            miso_bit[l]--;
            spi_miso[l] = miso_word[l][miso_bit[l]];
         end
         if (!prev_le[l] && spi_le[l]) begin
            got_q.push_back(cap[l][53:0]);
            got_ch_q.push_back(l);
            spi_miso[l] = 1'b0;
         end
      end
      prev_le   = spi_le;
      prev_sclk = spi_sclk;
   end

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input logic [1:0] ch, input logic [7:0] nb, input logic [7:0] dv,
                           input logic rd, input logic [53:0] data);
      int t = 0;
      cmd_ch = ch; cmd_nbits = nb; cmd_div = dv; cmd_read = rd; cmd_data = data;
      cmd_valid = 1'b1;
      while (!cmd_ready && t < 5000) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 5000) begin
         n_checks++;
         $display("FAIL send_timeout: cmd_ready stuck at %b, want 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      @(posedge clk); #1;
      while (busy && t < 20000) begin
         @(posedge clk); #1; t++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, t);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++; if (spi_sclk !== 3'b000) $display("FAIL rst_sclk: got %b want 000", spi_sclk); else n_pass++;
      n_checks++; if (spi_mosi !== 3'b000) $display("FAIL rst_mosi: got %b want 000", spi_mosi); else n_pass++;
      n_checks++; if (spi_le !== 3'b111) $display("FAIL rst_le: got %b want 111", spi_le); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
      n_checks++; if (rsp_data !== 54'h0) $display("FAIL rst_rsp_data: got %h want 0", rsp_data); else n_pass++;
      n_checks++; if (rsp_ch !== 2'd0) $display("FAIL rst_rsp_ch: got %0d want 0", rsp_ch); else n_pass++;
      n_checks++; if (err_bad_cmd !== 1'b0) $display("FAIL rst_err: got %b want 0", err_bad_cmd); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
   endtask

   task automatic test_write();
      clear_mon();
      send_cmd(2'd0, 8'd32, 8'd5, 1'b0, 54'hDEAD_BEEF);
      wait_idle("write");
      n_checks++; if (rise_cnt[0] != 32) $display("FAIL write_rises: got %0d want 32", rise_cnt[0]); else n_pass++;
      n_checks++; if (cap[0][31:0] !== 32'hDEAD_BEEF) $display("FAIL write_mosi: got %h want deadbeef", cap[0][31:0]); else n_pass++;
      n_checks++; if (le_low_cnt[0] != 325) $display("FAIL write_le_low: got %0d want 325", le_low_cnt[0]); else n_pass++;
      n_checks++; if (active_cnt != 331) $display("FAIL write_latency: got %0d want 331", active_cnt); else n_pass++;
      n_checks++; if (rise_cnt[1] + rise_cnt[2] + le_low_cnt[1] + le_low_cnt[2] != 0)
         $display("FAIL write_idle_lanes: got %0d activity want 0", rise_cnt[1] + rise_cnt[2] + le_low_cnt[1] + le_low_cnt[2]); else n_pass++;
      n_checks++; if (rsp_cnt != 0) $display("FAIL write_no_rsp: got %0d want 0", rsp_cnt); else n_pass++;
      n_checks++; if (spi_mosi !== 3'b000) $display("FAIL write_mosi_idle: got %b want 000", spi_mosi); else n_pass++;
   endtask

   task automatic test_read();
      clear_mon();
      miso_word[1] = 54'hA5C3F0;
      miso_nb[1]   = 24;
      send_cmd(2'd1, 8'd24, 8'd2, 1'b1, 54'h123456);
      wait_idle("read");
      n_checks++; if (rsp_cnt != 1) $display("FAIL read_rsp_count: got %0d want 1", rsp_cnt); else n_pass++;
      n_checks++; if (rsp_align != 1) $display("FAIL read_rsp_at_le_rise: got %0d want 1", rsp_align); else n_pass++;
      n_checks++; if (rsp_ch_last !== 2'd1) $display("FAIL read_rsp_ch: got %0d want 1", rsp_ch_last); else n_pass++;
      n_checks++; if (rsp_data_last !== 54'hA5C3F0) $display("FAIL read_rsp_data: got %h want a5c3f0", rsp_data_last); else n_pass++;
      n_checks++; if (cap[1][23:0] !== 24'h123456) $display("FAIL read_mosi: got %h want 123456", cap[1][23:0]); else n_pass++;
      n_checks++; if (le_low_cnt[1] != 98) $display("FAIL read_le_low: got %0d want 98", le_low_cnt[1]); else n_pass++;
      n_checks++; if (rsp_data !== 54'hA5C3F0 || rsp_valid !== 1'b0)
         $display("FAIL read_rsp_hold: got data %h valid %b want a5c3f0 0", rsp_data, rsp_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [5];
      int ln [5];
      pat[0] = 8'hA1; pat[1] = 8'h5E; pat[2] = 8'h3C; pat[3] = 8'hF0; pat[4] = 8'h0F;
      ln[0] = 0; ln[1] = 1; ln[2] = 2; ln[3] = 0; ln[4] = 1;
      clear_mon();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({46'h0, pat[i]});
         exp_ch_q.push_back(ln[i]);
         send_cmd(2'(ln[i]), 8'd8, 8'd1, 1'b0, {46'h0, pat[i]});
         if (i == 1) begin
            n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL b2b_first_pop: state %0d want %0d", dbg_state, ST_LOAD); else n_pass++;
         end
      end
      n_checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_full: cmd_ready=%b want 0", cmd_ready); else n_pass++;
      wait_idle("b2b");
      n_checks++; if (got_q.size() != 5) $display("FAIL b2b_frames: got %0d want 5", got_q.size()); else n_pass++;
      for (int i = 0; i < 5 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i] || got_ch_q[i] != exp_ch_q[i])
            $display("FAIL b2b_order[%0d]: got ch%0d %h want ch%0d %h", i, got_ch_q[i], got_q[i], exp_ch_q[i], exp_q[i]);
         else n_pass++;
      end
      for (int i = 1; i < fall_q.size(); i++) begin
         n_checks++;
         if (fall_q[i] - fall_q[i-1] != 20) $display("FAIL b2b_spacing[%0d]: got %0d want 20", i, fall_q[i] - fall_q[i-1]);
         else n_pass++;
      end
      n_checks++; if (active_cnt != 95) $display("FAIL b2b_active: got %0d want 95", active_cnt); else n_pass++;
   endtask

   task automatic test_bad_cmd();
      clear_mon();
      send_cmd(2'd0, 8'd0, 8'd1, 1'b0, 54'h1);
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (err_cnt != 1) $display("FAIL bad_nbits0_err: got %0d want 1", err_cnt); else n_pass++;
      send_cmd(2'd0, 8'd55, 8'd1, 1'b0, 54'h1);
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (err_cnt != 2) $display("FAIL bad_nbits55_err: got %0d want 2", err_cnt); else n_pass++;
      send_cmd(2'd3, 8'd8, 8'd1, 1'b1, 54'h1);
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (err_cnt != 3) $display("FAIL bad_ch3_err: got %0d want 3", err_cnt); else n_pass++;
      n_checks++; if (busy_seen !== 1'b0) $display("FAIL bad_busy: busy seen %b want 0", busy_seen); else n_pass++;
      n_checks++; if (frame_cnt[0] + frame_cnt[1] + frame_cnt[2] != 0 || rsp_cnt != 0)
         $display("FAIL bad_activity: frames %0d rsp %0d want 0 0", frame_cnt[0] + frame_cnt[1] + frame_cnt[2], rsp_cnt); else n_pass++;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL bad_ready: got %b want 1", cmd_ready); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int t = 0;
      clear_mon();
      miso_word[2] = 54'h2A_5A5A_C3C3_F00F;
      miso_nb[2]   = 54;
      send_cmd(2'd2, 8'd54, 8'd2, 1'b1, 54'h15_1234_5678_9ABC);
      while (rise_cnt[2] < 10 && t < 2000) begin
         @(posedge clk); #1; t++;
      end
      n_checks++; if (rise_cnt[2] < 10) $display("FAIL midrst_reach_bit10: rises %0d want 10", rise_cnt[2]); else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (spi_sclk !== 3'b000) $display("FAIL midrst_sclk: got %b want 000", spi_sclk); else n_pass++;
      n_checks++; if (spi_le !== 3'b111) $display("FAIL midrst_le: got %b want 111", spi_le); else n_pass++;
      n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL midrst_fifo: busy %b ready %b want 0 1", busy, cmd_ready); else n_pass++;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (rsp_cnt != 0 || busy !== 1'b0) $display("FAIL midrst_no_rsp: rsp %0d busy %b want 0 0", rsp_cnt, busy); else n_pass++;
      clear_mon();
      miso_word[0] = 54'hB6D;
      miso_nb[0]   = 12;
      send_cmd(2'd0, 8'd12, 8'd3, 1'b1, 54'h5A5);
      wait_idle("midrst_after");
      n_checks++; if (rsp_cnt != 1 || rsp_data_last !== 54'hB6D || rsp_ch_last !== 2'd0)
         $display("FAIL midrst_after_rsp: cnt %0d data %h ch %0d want 1 b6d 0", rsp_cnt, rsp_data_last, rsp_ch_last); else n_pass++;
      n_checks++; if (active_cnt != 79) $display("FAIL midrst_after_latency: got %0d want 79", active_cnt); else n_pass++;
      n_checks++; if (got_q.size() != 1 || cap[0][11:0] !== 12'h5A5)
         $display("FAIL midrst_after_mosi: frames %0d data %h want 1 5a5", got_q.size(), cap[0][11:0]); else n_pass++;
   endtask

   task automatic test_div_zero();
      for (int k = 0; k < 2; k++) begin
         clear_mon();
         send_cmd(2'd1, 8'd5, 8'(k), 1'b0, 54'h16);
         wait_idle("div");
         n_checks++; if (active_cnt != 13) $display("FAIL div%0d_latency: got %0d want 13", k, active_cnt); else n_pass++;
         n_checks++; if (le_low_cnt[1] != 11 || rise_cnt[1] != 5)
            $display("FAIL div%0d_frame: le_low %0d rises %0d want 11 5", k, le_low_cnt[1], rise_cnt[1]); else n_pass++;
         n_checks++; if (cap[1][4:0] !== 5'h16) $display("FAIL div%0d_mosi: got %h want 16", k, cap[1][4:0]); else n_pass++;
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_bad_cmd();
      test_reset_mid_frame();
      test_div_zero();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #700us;
      $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
